// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter sequencer and its users.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEFAULT_STEP         = 1;

endpackage

// File: rtl/pc_redirect_buffer.sv
// One-entry holding register for a redirect that could not be applied yet.
// A new capture always overwrites the held target.
module pc_redirect_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture,
  input  logic             consume,
  input  logic [WIDTH-1:0] target_in,
  output logic             valid,
  output logic [WIDTH-1:0] target
);

  logic             valid_reg;
  logic [WIDTH-1:0] target_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      target_reg <= '0;
    end else if (capture) begin
      valid_reg  <= 1'b1;
      target_reg <= target_in;
    end else if (consume) begin
      valid_reg  <= 1'b0;
    end
  end

  assign valid  = valid_reg;
  assign target = target_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential stepping, redirects, stall,
// halt/resume and buffering of redirects that arrive while not advancing.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int unsigned      STEP         = DEFAULT_STEP,
  parameter int unsigned      CNT_WIDTH    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WIDTH-1:0]     redirect_target,
  input  logic                 halt,
  input  logic                 resume,
  output logic [WIDTH-1:0]     pc_out,
  output logic                 pc_valid,
  output logic                 redirect_pending,
  output logic [CNT_WIDTH-1:0] advance_count
);

  pc_state_t            state_reg;
  logic [WIDTH-1:0]     pc_reg;
  logic [WIDTH-1:0]     pc_next;
  logic                 valid_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 pend_valid;
  logic [WIDTH-1:0]     pend_target;
  logic                 run_go;
  logic                 capture;

  // The PC only moves in a RUN cycle that is neither halting nor stalled;
  // any redirect seen in another cycle is parked in the buffer.
  assign run_go  = (state_reg == RUN) && !halt && !stall;
  assign capture = redirect_valid && !run_go;

  pc_redirect_buffer #(
    .WIDTH (WIDTH)
  ) u_redirect_buffer (
    .clock     (clock),
    .reset     (reset),
    .capture   (capture),
    .consume   (run_go),
    .target_in (redirect_target),
    .valid     (pend_valid),
    .target    (pend_target)
  );

  always_comb begin
    pc_next = pc_reg;
    if (run_go) begin
      if (redirect_valid) begin
        pc_next = redirect_target;
      end else if (pend_valid) begin
        pc_next = pend_target;
      end else begin
        pc_next = pc_reg + WIDTH'(STEP);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_VECTOR;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg <= RUN;
          valid_reg <= !stall;
        end
        RUN: begin
          if (halt) begin
            state_reg <= HALTED;
            valid_reg <= 1'b0;
          end else begin
            valid_reg <= !stall;
          end
        end
        HALTED: begin
          if (resume && !halt) begin
            state_reg <= RUN;
            valid_reg <= !stall;
          end else begin
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= BOOT;
          valid_reg <= 1'b0;
        end
      endcase
      pc_reg <= pc_next;
      if (run_go) begin
        count_reg <= count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign pc_out           = pc_reg;
  assign pc_valid         = valid_reg;
  assign redirect_pending = pend_valid;
  assign advance_count    = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each driven cycle pushes the expected
// registered outputs, which are popped and compared after the clock edge.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0100;
  localparam int unsigned ST = 4;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        resume;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        redirect_pending;
  logic [31:0] advance_count;

  pc_sequencer #(
    .WIDTH        (32),
    .RESET_VECTOR (RV),
    .STEP         (ST),
    .CNT_WIDTH    (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .halt             (halt),
    .resume           (resume),
    .pc_out           (pc_out),
    .pc_valid         (pc_valid),
    .redirect_pending (redirect_pending),
    .advance_count    (advance_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Reference model state
  pc_state_t   m_state = BOOT;
  logic [31:0] m_pc    = '0;
  logic        m_valid = 1'b0;
  logic        m_pend  = 1'b0;
  logic [31:0] m_ptgt  = '0;
  logic [31:0] m_cnt   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  task automatic buffer_redirect(input logic rv, input logic [31:0] tg);
    if (rv) begin
      m_pend = 1'b1;
      m_ptgt = tg;
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic rv,
                     input logic [31:0] tg, input logic hl, input logic rs);
    exp_t e;
    @(negedge clock);
    reset = rst; stall = st; redirect_valid = rv;
    redirect_target = tg; halt = hl; resume = rs;
    if (rst) begin
      m_state = BOOT; m_pc = RV; m_valid = 1'b0;
      m_pend = 1'b0; m_ptgt = '0; m_cnt = '0;
    end else begin
      case (m_state)
        BOOT: begin
          buffer_redirect(rv, tg);
          m_state = RUN;
          m_valid = !st;
        end
        RUN: begin
          if (hl) begin
            buffer_redirect(rv, tg);
            m_state = HALTED;
            m_valid = 1'b0;
          end else if (st) begin
            buffer_redirect(rv, tg);
            m_valid = 1'b0;
          end else begin
            m_valid = 1'b1;
            if (rv) begin
              m_pc = tg; m_pend = 1'b0;
            end else if (m_pend) begin
              m_pc = m_ptgt; m_pend = 1'b0;
            end else begin
              m_pc = m_pc + ST;
            end
            m_cnt = m_cnt + 1;
          end
        end
        default: begin
          buffer_redirect(rv, tg);
          if (rs && !hl) begin
            m_state = RUN;
            m_valid = !st;
          end else begin
            m_valid = 1'b0;
          end
        end
      endcase
    end
    e.pc = m_pc; e.valid = m_valid; e.pend = m_pend; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    txn++;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      $display("txn %0d rst=%b st=%b rv=%b tg=%h hl=%b rs=%b -> pc=%h v=%b p=%b cnt=%0d",
               txn, rst, st, rv, tg, hl, rs, pc_out, pc_valid, redirect_pending, advance_count);
      check("pc_out", 64'(pc_out), 64'(e.pc));
      check("pc_valid", 64'(pc_valid), 64'(e.valid));
      check("redirect_pending", 64'(redirect_pending), 64'(e.pend));
      check("advance_count", 64'(advance_count), 64'(e.cnt));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; halt = 1'b0; resume = 1'b0;

    // Reset, then BOOT -> RUN -> two increments
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("reset_pc", 64'(pc_out), 64'h100);
    check("reset_valid", 64'(pc_valid), 64'd0);
    idle(3);
    check("boot_seq_pc", 64'(pc_out), 64'h108);
    check("boot_seq_cnt", 64'(advance_count), 64'd2);

    // Redirect to 0x10, then to 0x40 from 0x10
    cyc(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    check("redirect_pc", 64'(pc_out), 64'h40);
    idle(1);
    check("redirect_step", 64'(pc_out), 64'h44);

    // Stall 3 cycles with latest-wins buffered redirects
    cyc(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
    check("stall_hold", 64'(pc_out), 64'h44);
    check("stall_pending", 64'(redirect_pending), 64'd1);
    idle(1);
    check("pending_apply", 64'(pc_out), 64'h300);
    idle(1);

    // Modulo wrap at 2^32 - STEP
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    idle(1);
    check("wrap_pc", 64'(pc_out), 64'h0);
    idle(1);

    // Halt with simultaneous redirect, then resume
    cyc(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
    check("halt_pc", 64'(pc_out), 64'h20);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("resume_pc", 64'(pc_out), 64'h20);
    check("resume_valid", 64'(pc_valid), 64'd1);
    idle(1);
    check("resume_apply", 64'(pc_out), 64'h80);
    idle(1);

    // Reset while a redirect is buffered in HALTED, then BOOT buffering
    cyc(1'b0, 1'b0, 1'b1, 32'h90, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("reset_clears_pend", 64'(redirect_pending), 64'd0);
    check("reset_clears_cnt", 64'(advance_count), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
    idle(1);
    check("boot_buffered_pc", 64'(pc_out), 64'h500);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 25), $urandom,
          ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 30));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
